// File: rtl/au_pkg.sv
// au_pkg: shared opcode/state encodings and default widths for the multi-cycle arithmetic unit.
package au_pkg;
    localparam int DEF_W     = 2;
    localparam int DEF_ITERS = DEF_W;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_EXEC,
        ST_DONE
    } st_t;
endpackage

// File: rtl/au_iter_muldiv.sv
// au_iter_muldiv: one-bit-per-step shift-add multiplier and restoring divider.
// Outputs show the value the current step produces, so the caller can capture the final bit on the same edge.
module au_iter_muldiv #(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div0
);
    logic [2*W-1:0] acc, mcand;
    logic [W-1:0]   mplier, rem, quo, dvd, dvs;
    logic [W:0]     trial, trial_sub;
    logic           fits;

    always_comb begin
        product   = acc + (mplier[0] ? mcand : '0);
        trial     = {rem, dvd[W-1]};
        fits      = trial >= {1'b0, dvs};
        trial_sub = fits ? trial - {1'b0, dvs} : trial;
        remainder = trial_sub[W-1:0];
        quotient  = {quo[W-2:0], fits};
        div0      = dvs == '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvd    <= '0;
            dvs    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            rem    <= '0;
            quo    <= '0;
            dvd    <= a;
            dvs    <= b;
        end else if (step && !is_div) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (step) begin
            rem    <= remainder;
            quo    <= quotient;
            dvd    <= dvd << 1;
        end
    end
endmodule

// File: rtl/au_multicycle.sv
// au_multicycle: free-running 4-cycle arithmetic unit (ADD/SUB/MUL/DIV) with registered result and done strobe.
module au_multicycle
    import au_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ITERS = DEF_ITERS
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     ctrl,
    output logic [2*W-1:0] y,
    output logic           c,
    output logic           done
);
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    st_t            state, state_n;
    op_t            op;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   ar, br, quotient, remainder;
    logic [W:0]     as_r;
    logic [2*W-1:0] product, y_n;
    logic           last, c_n, div0;

    au_iter_muldiv #(.W(W)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_LOAD),
        .step     (state == ST_EXEC),
        .is_div   (op == OP_DIV),
        .a        (a),
        .b        (b),
        .product  (product),
        .quotient (quotient),
        .remainder(remainder),
        .div0     (div0)
    );

    // Top bit of as_r is the ADD carry or the SUB borrow.
    always_comb begin
        last    = cnt == CW'(ITERS - 1);
        state_n = (state == ST_LOAD) ? ST_EXEC :
                  (state == ST_EXEC) ? (last ? ST_DONE : ST_EXEC) : ST_LOAD;
        y_n     = (op == OP_ADD) ? {{(W-1){1'b0}}, as_r} :
                  (op == OP_SUB) ? {{W{1'b0}}, as_r[W-1:0]} :
                  (op == OP_MUL) ? product :
                  div0 ? '1 : {remainder, quotient};
        c_n     = (op == OP_ADD || op == OP_SUB) ? as_r[W] : (op == OP_DIV) && div0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
            cnt   <= '0;
            op    <= OP_ADD;
            ar    <= '0;
            br    <= '0;
            as_r  <= '0;
            y     <= '0;
            c     <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state == ST_EXEC && !last) ? cnt + CW'(1) : '0;
            done  <= state == ST_EXEC && last;
            if (state == ST_LOAD) begin
                ar <= a;
                br <= b;
                op <= op_t'(ctrl);
            end
            if (state == ST_EXEC && cnt == '0)
                as_r <= (op == OP_SUB) ? {1'b0, ar} - {1'b0, br} : {1'b0, ar} + {1'b0, br};
            if (state == ST_EXEC && last) begin
                y <= y_n;
                c <= c_n;
            end
        end
    end
endmodule

// File: tb/tb_au_multicycle.sv
// tb_au_multicycle: directed scoreboard bench for au_multicycle.
module tb_au_multicycle;
    import au_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] a = '0, b = '0, ctrl = '0;
    logic [3:0] y;
    logic       c, done;
    int         checks = 0, errors = 0;
    logic [4:0] sb[$];

    au_multicycle dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .ctrl (ctrl),
        .y    (y),
        .c    (c),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just before a sampling edge; returns just before the next one.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] xa, input logic [1:0] xb,
                          input logic [3:0] ey, input logic ec);
        int         n;
        logic [4:0] e;
        ctrl = op;
        a    = xa;
        b    = xb;
        sb.push_back({ec, ey});
        @(posedge clk);
        #1;
        ctrl = ~op;
        a    = ~xa;
        b    = xb + 2'd1;
        n    = 1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 10);
        chk({tag, " latency"}, 8'(n), 8'd3);
        e = sb.pop_front();
        chk({tag, " y"}, 8'(y), 8'(e[3:0]));
        chk({tag, " c"}, 8'(c), 8'(e[4]));
        @(posedge clk);
        #1;
        chk({tag, " done_width"}, 8'(done), 8'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset y", 8'(y), 8'd0);
        chk("reset c", 8'(c), 8'd0);
        chk("reset done", 8'(done), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("add_2_1", OP_ADD, 2'd2, 2'd1, 4'd3, 1'b0);
        run_op("add_3_3", OP_ADD, 2'd3, 2'd3, 4'd6, 1'b1);
        run_op("add_0_0", OP_ADD, 2'd0, 2'd0, 4'd0, 1'b0);
        run_op("sub_2_1", OP_SUB, 2'd2, 2'd1, 4'd1, 1'b0);
        run_op("sub_1_2", OP_SUB, 2'd1, 2'd2, 4'd3, 1'b1);
        run_op("sub_0_3", OP_SUB, 2'd0, 2'd3, 4'd1, 1'b1);
        run_op("mul_2_2", OP_MUL, 2'd2, 2'd2, 4'd4, 1'b0);
        run_op("mul_3_3", OP_MUL, 2'd3, 2'd3, 4'd9, 1'b0);
        run_op("mul_3_0", OP_MUL, 2'd3, 2'd0, 4'd0, 1'b0);
        run_op("div_2_1", OP_DIV, 2'd2, 2'd1, 4'b0010, 1'b0);
        run_op("div_3_2", OP_DIV, 2'd3, 2'd2, 4'b0101, 1'b0);
        run_op("div_3_1", OP_DIV, 2'd3, 2'd1, 4'b0011, 1'b0);
        run_op("div_2_0", OP_DIV, 2'd2, 2'd0, 4'hF, 1'b1);
        run_op("add_1_2", OP_ADD, 2'd1, 2'd2, 4'd3, 1'b0);
        ctrl = OP_MUL;
        a    = 2'd3;
        b    = 2'd3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort y", 8'(y), 8'd0);
        chk("abort c", 8'(c), 8'd0);
        @(posedge clk);
        #1;
        chk("abort done", 8'(done), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("abort hold y", 8'(y), 8'd0);
        run_op("div_0_3", OP_DIV, 2'd0, 2'd3, 4'b0000, 1'b0);
        run_op("sub_3_3", OP_SUB, 2'd3, 2'd3, 4'd0, 1'b0);
        chk("scoreboard empty", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
